// File: rtl/alu_pkg.sv
// Purpose: shared types and width for the 8-bit signed ALU slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int W = 8;

    // Encodings 0..7 match the sel port directly.
    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        AND = 3'd3,
        OR  = 3'd4,
        XOR = 3'd5,
        SRA = 3'd6,
        SLT = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational result of one ALU operation on two signed 8-bit operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; a result is produced for every input combination.
//
// Ports:
//   sel - operation select (alu_op_e encoding)
//   A   - signed operand A
//   B   - signed operand B (only B[2:0] matters for SRA)
//   res - operation result, wrapping modulo 256 for ADD/SUB/MUL
module alu_core
    import alu_pkg::*;
(
    input  logic        [2:0]   sel,
    input  logic signed [W-1:0] A,
    input  logic signed [W-1:0] B,
    output logic        [W-1:0] res
);

    always_comb begin
        res = '0;
        case (alu_op_e'(sel))
            ADD: res = A + B;
            SUB: res = A - B;
            // The low byte of a two's-complement product does not depend on
            // the sign interpretation, so an 8-bit-wide multiply gives exactly
            // the low 8 bits of the signed 16-bit product.
            MUL: res = A * B;
            AND: res = A & B;
            OR:  res = A | B;
            XOR: res = A ^ B;
            // Shift amount is deliberately limited to B[2:0]; upper bits ignored.
            SRA: res = A >>> B[2:0];
            SLT: res = (A < B) ? W'(1) : W'(0);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_ip.sv
// Purpose: registered 8-bit signed ALU with zero flag.
// Latency: 1 cycle from inputs to C/Z; a new operation is accepted every cycle.
// Backpressure: none; no handshake, results are never stalled.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (C <= 0, Z <= 1), overrides any operation
//   sel - operation select
//   A   - signed operand A
//   B   - signed operand B
//   C   - registered result
//   Z   - registered zero flag, set when the loaded C is zero
module alu_ip
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic        [2:0]  sel,
    input  logic signed [7:0]  A,
    input  logic signed [7:0]  B,
    output logic signed [7:0]  C,
    output logic               Z
);

    logic [W-1:0] res;

    alu_core u_core (
        .sel (sel),
        .A   (A),
        .B   (B),
        .res (res)
    );

    // Z is derived from the same combinational result that loads C, so the
    // two registers always agree with each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            C <= '0;
            Z <= 1'b1;
        end else begin
            C <= res;
            Z <= (res == '0);
        end
    end

endmodule

// File: tb/tb_alu_ip.sv
module tb_alu_ip;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic        [2:0] sel;
    logic signed [7:0] A;
    logic signed [7:0] B;
    logic signed [7:0] C;
    logic              Z;

    alu_ip dut (
        .clk (clk),
        .rst (rst),
        .sel (sel),
        .A   (A),
        .B   (B),
        .C   (C),
        .Z   (Z)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] c;
        logic       z;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    // Independent reference: integer arithmetic, then keep the low byte.
    function automatic logic [8:0] model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (s)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = sa * sb;
            3'd3: r = int'(a & b);
            3'd4: r = int'(a | b);
            3'd5: r = int'(a ^ b);
            3'd6: r = sa >>> b[2:0];
            3'd7: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        return {(r[7:0] == 8'h00), r[7:0]};
    endfunction

    task automatic check_out();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=no_expectation expected=queued_result");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (C === e.c) else begin
            errors++;
            $error("FAIL %s_C observed=%0d (0x%h) expected=%0d (0x%h)", t, C, C, $signed(e.c), e.c);
        end
        checks++;
        assert (Z === e.z) else begin
            errors++;
            $error("FAIL %s_Z observed=%b expected=%b", t, Z, e.z);
        end
    endtask

    // Drive one operation, queue its expectation, and compare one cycle later.
    task automatic step(input logic r, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ec, input logic ez, input string t);
        exp_t e;
        rst = r;
        sel = s;
        A   = a;
        B   = b;
        e.c = ec;
        e.z = ez;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [2:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] m;

        rst = 1'b1;
        sel = 3'd0;
        A   = 8'sd0;
        B   = 8'sd0;
        @(posedge clk);
        #1;

        // Reset held two cycles with an ADD presented, then released.
        step(1'b1, ADD, 8'd5, 8'd3, 8'h00, 1'b1, "reset_cyc1");
        step(1'b1, ADD, 8'd5, 8'd3, 8'h00, 1'b1, "reset_cyc2");
        step(1'b0, ADD, 8'd5, 8'd3, 8'h08, 1'b0, "reset_release_add");

        // Arithmetic wrap.
        step(1'b0, ADD, 8'h7F, 8'h01, 8'h80, 1'b0, "add_wrap");
        step(1'b0, SUB, 8'h80, 8'h01, 8'h7F, 1'b0, "sub_wrap");
        step(1'b0, SUB, 8'h07, 8'h07, 8'h00, 1'b1, "sub_zero");

        // Multiply and logic.
        step(1'b0, MUL, 8'hFD, 8'h05, 8'hF1, 1'b0, "mul_neg");
        step(1'b0, MUL, 8'h10, 8'h10, 8'h00, 1'b1, "mul_wrap_zero");
        step(1'b0, AND, 8'h5A, 8'h0F, 8'h0A, 1'b0, "and");
        step(1'b0, OR,  8'h50, 8'h0A, 8'h5A, 1'b0, "or");
        step(1'b0, XOR, 8'h55, 8'h55, 8'h00, 1'b1, "xor_zero");

        // Shift and compare.
        step(1'b0, SRA, 8'h80, 8'h03, 8'hF0, 1'b0, "sra_neg");
        step(1'b0, SRA, 8'h40, 8'h09, 8'h20, 1'b0, "sra_b_upper_ignored");
        step(1'b0, SLT, 8'hFF, 8'h01, 8'h01, 1'b0, "slt_true");
        step(1'b0, SLT, 8'h01, 8'hFF, 8'h00, 1'b1, "slt_false");

        // Back-to-back stream over all opcodes, with a one-cycle reset mid-stream.
        for (int i = 0; i < 24; i++) begin
            s = 3'(i);
            a = 8'($urandom);
            b = 8'($urandom);
            if (i == 13) begin
                step(1'b1, s, a, b, 8'h00, 1'b1, "stream_mid_reset");
            end else begin
                m = model(s, a, b);
                step(1'b0, s, a, b, m[7:0], m[8], "stream");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
